// File: rtl/response_misr_checker_pkg.sv
// Shared definitions for the HelloWorld response checker.
// Holds response bit order, MISR constants and checker states.
package helloworld_pkg;

    localparam int RESP_W = 16;

    localparam logic [RESP_W-1:0] MISR_POLY = 16'hB400;
    localparam logic [RESP_W-1:0] MISR_SEED = 16'hFFFF;

    // FINAL_OUTPUT net positions within resp_data
    localparam int BIT_Z0RE  = 0;
    localparam int BIT_U39AH = 15;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        DONE
    } chk_state_t;

endpackage

// File: rtl/response_misr_checker_if.sv
// Run-control and result bundle between a response source and the checker.
// The master drives run control and samples; the slave returns status.
interface response_misr_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 9
);
    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic [WIDTH-1:0] golden_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] sample_count;

    modport master (
        output start, resp_valid, resp_data, golden_sig,
        input  busy, done, pass, signature, sample_count
    );

    modport slave (
        input  start, resp_valid, resp_data, golden_sig,
        output busy, done, pass, signature, sample_count
    );
endinterface

// File: rtl/response_misr_checker_misr_core.sv
// Galois MISR register with synchronous load and absorb enable.
// nxt exposes the step function so an LFSR source can share it.
module misr_core
    import helloworld_pkg::*;
#(
    parameter int               WIDTH = RESP_W,
    parameter logic [WIDTH-1:0] POLY  = MISR_POLY,
    parameter logic [WIDTH-1:0] SEED  = MISR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = (sig >> 1) ^ (sig[0] ? POLY : '0) ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= nxt;
        end
    end

endmodule

// File: rtl/response_misr_checker.sv
// Compacts CYCLES valid response samples into a MISR signature,
// then compares it once against golden_sig and reports pass/done.
module response_misr_checker
    import helloworld_pkg::*;
#(
    parameter int               WIDTH  = RESP_W,
    parameter int               CYCLES = 256,
    parameter logic [WIDTH-1:0] POLY   = MISR_POLY,
    parameter logic [WIDTH-1:0] SEED   = MISR_SEED,
    parameter int               CNT_W  = 9
) (
    input  logic                    bertaClock,
    input  logic                    global_reset,
    response_misr_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    chk_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             load;
    logic             en;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] nxt_unused;

    assign load = bus.start && (state == IDLE || state == DONE);
    assign en   = bus.resp_valid && (state == COLLECT);

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (bertaClock),
        .rst  (global_reset),
        .load (load),
        .en   (en),
        .din  (bus.resp_data),
        .sig  (sig),
        .nxt  (nxt_unused)
    );

    always_ff @(posedge bertaClock or posedge global_reset) begin
        if (global_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= COLLECT;
                        cnt    <= '0;
                        pass_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.resp_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    pass_q <= (sig == bus.golden_sig);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.signature    = sig;
    assign bus.sample_count = cnt;

    // Unknown sample bits would silently poison the signature
    a_data_known: assert property (
        @(posedge bertaClock) disable iff (global_reset)
        bus.resp_valid |-> !$isunknown(bus.resp_data)
    );

endmodule
